// File: rtl/mem_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_data_arbiter
// Purpose  : Shares one single-port data memory (synchronous write, 1-cycle
//            registered read) between the pipeline MEM stage (port A) and a
//            debug/DMA master (port B). Grants at most one access per cycle,
//            drives the memory control lines and steers the registered read
//            data back to whichever port issued the read. Port A wins by
//            default; a starvation counter hands priority to port B after
//            p_STARVE_LIMIT consecutive denied cycles.
// Ports    : i_clk, i_rst             clock, synchronous active-high reset
//            i_a_* / o_a_*            port A request, grant and read return
//            i_b_* / o_b_*            port B request, grant and read return
//            o_mem_wr_en/addr/wr_data memory write enable, address, data
//            i_mem_rd_data            memory registered read data
// Revision : 1.0  initial release
// ============================================================================
module mem_data_arbiter #(
  parameter int p_WORD_LEN     = 16,
  parameter int p_ADDR_LEN     = 10,
  parameter int p_STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_a_req,
  input  logic                  i_a_we,
  input  logic [p_ADDR_LEN-1:0] i_a_addr,
  input  logic [p_WORD_LEN-1:0] i_a_wr_data,
  output logic                  o_a_gnt,
  output logic                  o_a_rd_valid,
  output logic [p_WORD_LEN-1:0] o_a_rd_data,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [p_ADDR_LEN-1:0] i_b_addr,
  input  logic [p_WORD_LEN-1:0] i_b_wr_data,
  output logic                  o_b_gnt,
  output logic                  o_b_rd_valid,
  output logic [p_WORD_LEN-1:0] o_b_rd_data,
  output logic                  o_mem_wr_en,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

  localparam int                  c_WAIT_W = $clog2(p_STARVE_LIMIT + 1);
  localparam logic [c_WAIT_W-1:0] c_LIMIT  = c_WAIT_W'(p_STARVE_LIMIT);

  logic [c_WAIT_W-1:0] r_b_wait;
  logic                r_rd_pend_a;
  logic                r_rd_pend_b;
  logic                w_b_prio;
  logic                w_a_gnt;
  logic                w_b_gnt;

  // B only jumps ahead of a requesting A once it has been starved long enough.
  assign w_b_prio = (r_b_wait == c_LIMIT);
  assign w_b_gnt  = ~i_rst & i_b_req & (w_b_prio | ~i_a_req);
  assign w_a_gnt  = ~i_rst & i_a_req & ~w_b_gnt;

  assign o_a_gnt  = w_a_gnt;
  assign o_b_gnt  = w_b_gnt;

  assign o_mem_addr    = w_b_gnt ? i_b_addr    : i_a_addr;
  assign o_mem_wr_data = w_b_gnt ? i_b_wr_data : i_a_wr_data;
  assign o_mem_wr_en   = (w_a_gnt & i_a_we) | (w_b_gnt & i_b_we);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_b_wait    <= '0;
      r_rd_pend_a <= 1'b0;
      r_rd_pend_b <= 1'b0;
    end else begin
      if (w_b_gnt || !i_b_req) begin
        r_b_wait <= '0;
      end else if (r_b_wait != c_LIMIT) begin
        r_b_wait <= r_b_wait + 1'b1;
      end
      r_rd_pend_a <= w_a_gnt & ~i_a_we;
      r_rd_pend_b <= w_b_gnt & ~i_b_we;
    end
  end

  // A read granted just before reset must not report data while reset is
  // held; the pending flags are cleared by that same reset edge afterwards.
  assign o_a_rd_valid = r_rd_pend_a & ~i_rst;
  assign o_b_rd_valid = r_rd_pend_b & ~i_rst;

  // The memory has a single read port, so both ports see the same data and
  // only the matching valid qualifies it.
  assign o_a_rd_data = i_mem_rd_data;
  assign o_b_rd_data = i_mem_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_data_arbiter
// Purpose  : Self-checking bench for mem_data_arbiter with a behavioural
//            memory, a directed vector table, hand-written reset and
//            starvation sequences, and randomized traffic checked against a
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_data_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [15:0] a_wd, b_wd;
  logic        a_gnt, b_gnt, a_rv, b_rv;
  logic [15:0] a_rd, b_rd;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wd, mem_rd;

  logic [15:0] mem [0:1023];
  logic [15:0] ref_mem [0:15];

  int n_checks = 0;
  int n_pass   = 0;

  mem_data_arbiter #(
    .p_WORD_LEN(16), .p_ADDR_LEN(10), .p_STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wr_data(a_wd),
    .o_a_gnt(a_gnt), .o_a_rd_valid(a_rv), .o_a_rd_data(a_rd),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wr_data(b_wd),
    .o_b_gnt(b_gnt), .o_b_rd_valid(b_rv), .o_b_rd_data(b_rd),
    .o_mem_wr_en(mem_we), .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wd),
    .i_mem_rd_data(mem_rd)
  );

  always #5 clk = ~clk;

  // Single-port memory: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    mem_rd <= mem[mem_addr];
  end

  typedef struct {
    logic        a_req, a_we;
    logic [9:0]  a_addr;
    logic [15:0] a_wd;
    logic        b_req, b_we;
    logic [9:0]  b_addr;
    logic [15:0] b_wd;
    logic        e_ag, e_bg, e_we, e_av, e_bv;
    logic [15:0] e_data;
    logic [9:0]  e_addr;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    input logic ar, input logic aw, input logic [9:0] aa, input logic [15:0] ad,
    input logic br, input logic bw, input logic [9:0] ba, input logic [15:0] bd,
    input logic ag, input logic bg, input logic we, input logic av, input logic bv,
    input logic [15:0] dat, input logic [9:0] ea);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wd = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wd = bd;
    v.e_ag = ag; v.e_bg = bg; v.e_we = we; v.e_av = av; v.e_bv = bv;
    v.e_data = dat; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [9:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [9:0] ba, input logic [15:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wd = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wd = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
    mem_rd = 16'h0;

    // ---------------- reset with both ports requesting writes ----------------
    rst = 1'b1;
    drive(1'b1, 1'b1, 10'h005, 16'hFFFF, 1'b1, 1'b1, 10'h006, 16'hFFFF);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_wr_en", mem_we, 0);
      chk("rst_a_valid", a_rv, 0);
      chk("rst_b_valid", b_rv, 0);
      next_cycle();
    end
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    tbl[0]  = mk(1,1,10'h010,16'hBEEF, 0,0,10'h000,16'h0000, 1,0,1,0,0,16'h0000,10'h010);
    tbl[1]  = mk(1,0,10'h010,16'h0000, 0,0,10'h000,16'h0000, 1,0,0,0,0,16'h0000,10'h010);
    tbl[2]  = mk(0,0,10'h000,16'h0000, 1,1,10'h3FF,16'h1234, 0,1,1,1,0,16'hBEEF,10'h3FF);
    tbl[3]  = mk(1,1,10'h001,16'hAAAA, 0,0,10'h000,16'h0000, 1,0,1,0,0,16'h0000,10'h001);
    tbl[4]  = mk(0,0,10'h000,16'h0000, 1,1,10'h002,16'h5555, 0,1,1,0,0,16'h0000,10'h002);
    tbl[5]  = mk(0,0,10'h000,16'h0000, 1,0,10'h3FF,16'h0000, 0,1,0,0,0,16'h0000,10'h3FF);
    tbl[6]  = mk(1,0,10'h001,16'h0000, 0,0,10'h000,16'h0000, 1,0,0,0,1,16'h1234,10'h001);
    tbl[7]  = mk(0,0,10'h000,16'h0000, 1,0,10'h002,16'h0000, 0,1,0,1,0,16'hAAAA,10'h002);
    tbl[8]  = mk(0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0,0,0,1,16'h5555,10'h000);
    tbl[9]  = mk(1,1,10'h020,16'h1111, 1,0,10'h002,16'h0000, 1,0,1,0,0,16'h0000,10'h020);
    tbl[10] = mk(0,0,10'h000,16'h0000, 1,0,10'h002,16'h0000, 0,1,0,0,0,16'h0000,10'h002);
    tbl[11] = mk(1,0,10'h020,16'h0000, 0,0,10'h000,16'h0000, 1,0,0,0,1,16'h5555,10'h020);
    tbl[12] = mk(0,0,10'h000,16'h0000, 0,0,10'h000,16'h0000, 0,0,0,1,0,16'h1111,10'h000);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].a_req, tbl[i].a_we, tbl[i].a_addr, tbl[i].a_wd,
            tbl[i].b_req, tbl[i].b_we, tbl[i].b_addr, tbl[i].b_wd);
      @(negedge clk);
      if (i == 0) chk("post_rst_b_wait", 32'(dut.r_b_wait), 0);
      chk($sformatf("v%0d_a_gnt", i), a_gnt, tbl[i].e_ag);
      chk($sformatf("v%0d_b_gnt", i), b_gnt, tbl[i].e_bg);
      chk($sformatf("v%0d_wr_en", i), mem_we, tbl[i].e_we);
      chk($sformatf("v%0d_a_valid", i), a_rv, tbl[i].e_av);
      chk($sformatf("v%0d_b_valid", i), b_rv, tbl[i].e_bv);
      if (tbl[i].e_ag || tbl[i].e_bg) chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_we)
        chk($sformatf("v%0d_wdata", i), mem_wd, tbl[i].e_bg ? tbl[i].b_wd : tbl[i].a_wd);
      if (tbl[i].e_av) chk($sformatf("v%0d_a_data", i), a_rd, tbl[i].e_data);
      if (tbl[i].e_bv) chk($sformatf("v%0d_b_data", i), b_rd, tbl[i].e_data);
      next_cycle();
    end

    // ---------------- starvation: A reads every cycle, B always requests ----------------
    begin
      logic prev_ag, prev_bg, eb;
      prev_ag = 1'b0; prev_bg = 1'b0;
      for (int k = 1; k <= 11; k++) begin
        if (k <= 10) drive(1'b1, 1'b0, 10'h001, 16'h0, 1'b1, 1'b0, 10'h002, 16'h0);
        else         drive(1'b0, 1'b0, 10'h000, 16'h0, 1'b0, 1'b0, 10'h000, 16'h0);
        eb = (k <= 10) && (k % (LIMIT + 1) == 0);
        @(negedge clk);
        if (k <= 10) begin
          chk($sformatf("starve%0d_b_gnt", k), b_gnt, eb);
          chk($sformatf("starve%0d_a_gnt", k), a_gnt, !eb);
        end
        chk($sformatf("starve%0d_a_valid", k), a_rv, prev_ag);
        chk($sformatf("starve%0d_b_valid", k), b_rv, prev_bg);
        if (prev_ag) chk($sformatf("starve%0d_a_data", k), a_rd, 16'hAAAA);
        if (prev_bg) chk($sformatf("starve%0d_b_data", k), b_rd, 16'h5555);
        prev_ag = (k <= 10) && !eb;
        prev_bg = eb;
        next_cycle();
      end
    end

    // ---------------- reset in the cycle after a read grant ----------------
    drive(1'b1, 1'b0, 10'h001, 16'h0, 1'b0, 1'b0, 10'h000, 16'h0);
    @(negedge clk);
    chk("rmr_read_gnt", a_gnt, 1);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 1'b1, 10'h001, 16'hDEAD, 1'b0, 1'b0, 10'h000, 16'h0);
    @(negedge clk);
    chk("rmr_in_rst_a_gnt", a_gnt, 0);
    chk("rmr_in_rst_wr_en", mem_we, 0);
    chk("rmr_in_rst_a_valid", a_rv, 0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 10'h000, 16'h0, 1'b0, 1'b0, 10'h000, 16'h0);
    @(negedge clk);
    chk("rmr_after_a_valid", a_rv, 0);
    chk("rmr_after_b_valid", b_rv, 0);
    next_cycle();
    drive(1'b1, 1'b0, 10'h001, 16'h0, 1'b0, 1'b0, 10'h000, 16'h0);
    @(negedge clk);
    chk("rmr_reread_gnt", a_gnt, 1);
    next_cycle();
    drive(1'b0, 1'b0, 10'h000, 16'h0, 1'b0, 1'b0, 10'h000, 16'h0);
    @(negedge clk);
    chk("rmr_reread_valid", a_rv, 1);
    chk("rmr_mem_unchanged", a_rd, 16'hAAAA);
    next_cycle();
    next_cycle();

    // ---------------- randomized traffic against a reference model ----------------
    begin
      int          b_denied;
      logic        pav, pbv, a_hold, b_hold, ea, eb;
      logic [15:0] pdata;
      b_denied = 0; pav = 1'b0; pbv = 1'b0; a_hold = 1'b0; b_hold = 1'b0;
      pdata = 16'h0;
      for (int c = 0; c < 400; c++) begin
        // A denied request stays on the bus unchanged until it wins.
        if (!a_hold) begin
          a_req  = ($urandom_range(0, 9) < 7);
          a_we   = 1'($urandom_range(0, 1));
          a_addr = 10'h100 + 10'($urandom_range(0, 15));
          a_wd   = 16'($urandom);
        end
        if (!b_hold) begin
          b_req  = ($urandom_range(0, 9) < 6);
          b_we   = 1'($urandom_range(0, 1));
          b_addr = 10'h100 + 10'($urandom_range(0, 15));
          b_wd   = 16'($urandom);
        end
        // B wins when A is idle or when B has already lost LIMIT times in a row.
        eb = b_req && (!a_req || b_denied >= LIMIT);
        ea = a_req && !eb;
        @(negedge clk);
        chk("rnd_a_gnt", a_gnt, ea);
        chk("rnd_b_gnt", b_gnt, eb);
        chk("rnd_wr_en", mem_we, (ea && a_we) || (eb && b_we));
        if (ea) chk("rnd_addr_a", mem_addr, a_addr);
        if (eb) chk("rnd_addr_b", mem_addr, b_addr);
        if (ea && a_we) chk("rnd_wdata_a", mem_wd, a_wd);
        if (eb && b_we) chk("rnd_wdata_b", mem_wd, b_wd);
        chk("rnd_a_valid", a_rv, pav);
        chk("rnd_b_valid", b_rv, pbv);
        if (pav) chk("rnd_a_data", a_rd, pdata);
        if (pbv) chk("rnd_b_data", b_rd, pdata);
        pav = ea && !a_we;
        pbv = eb && !b_we;
        if (pav) pdata = ref_mem[a_addr[3:0]];
        if (pbv) pdata = ref_mem[b_addr[3:0]];
        if (ea && a_we) ref_mem[a_addr[3:0]] = a_wd;
        if (eb && b_we) ref_mem[b_addr[3:0]] = b_wd;
        b_denied = (b_req && !eb) ? b_denied + 1 : 0;
        a_hold = a_req && !ea;
        b_hold = b_req && !eb;
        next_cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_data_arbiter.md
# mem_data_arbiter

Two-port arbiter that shares the single-port data memory (synchronous write, 1-cycle registered read) between the pipeline MEM stage (port A) and a debug/DMA master (port B). It grants at most one access per cycle and drives the memory's write-enable, address and write-data lines. It routes the registered read data back to the requester that issued the read, with a valid strobe. Port A has priority by default; a starvation counter guarantees port B forward progress.

## Interface
- p_WORD_LEN, 16, bits per data word
- p_ADDR_LEN, 10, memory address width
- p_STARVE_LIMIT, 4, consecutive denied cycles after which port B takes priority; legal range 1..255
---
- i_clk  in  1  clock; all state updates on posedge
- i_rst  in  1  reset; one clock, reset is synchronous and active-high
- i_a_req  in  1  port A access request (held until granted)
- i_a_we  in  1  port A write (1) / read (0)
- i_a_addr  in  p_ADDR_LEN  port A address
- i_a_wr_data  in  p_WORD_LEN  port A write data
- o_a_gnt  out  1  port A access accepted this cycle (combinational)
- o_a_rd_valid  out  1  port A read data valid (registered)
- o_a_rd_data  out  p_WORD_LEN  port A read data
- i_b_req, i_b_we, i_b_addr, i_b_wr_data, o_b_gnt, o_b_rd_valid, o_b_rd_data: same widths and meanings for port B
- o_mem_wr_en  out  1  to memory write enable
- o_mem_addr  out  p_ADDR_LEN  to memory address
- o_mem_wr_data  out  p_WORD_LEN  to memory write data
- i_mem_rd_data  in  p_WORD_LEN  from memory registered read data

## Operation
- Grant logic is combinational from the current requests and the registered priority flag:
  - r_b_prio = (r_b_wait == p_STARVE_LIMIT).
  - o_b_gnt = i_b_req & (r_b_prio | ~i_a_req).
  - o_a_gnt = i_a_req & ~o_b_gnt.
  - While i_rst = 1, both grants = 0 and o_mem_wr_en = 0.
- At most one grant per cycle. A request with no grant must be held by the requester, with its fields stable, until it is granted.
- Memory mux:
  - When o_b_gnt = 1, o_mem_addr and o_mem_wr_data come from port B; otherwise they come from port A.
  - o_mem_wr_en = (o_a_gnt & i_a_we) | (o_b_gnt & i_b_we).
- Starvation counter r_b_wait, width $clog2(p_STARVE_LIMIT+1):
  - Cleared to 0 when o_b_gnt = 1 or i_b_req = 0.
  - Otherwise (B requesting and denied), increments, saturating at p_STARVE_LIMIT.
- Read return tracking:
  - r_rd_pend_a <= o_a_gnt & ~i_a_we.
  - r_rd_pend_b <= o_b_gnt & ~i_b_we.
  - o_a_rd_valid = r_rd_pend_a; o_b_rd_valid = r_rd_pend_b; both are mutually exclusive.
  - o_a_rd_data = o_b_rd_data = i_mem_rd_data. Data is qualified only by the matching valid.
- Writes produce no response; the grant is the completion.
- Read issued the cycle after a write to the same address returns the new value. Only one access per cycle, so there is no same-cycle read/write conflict.

## Timing
- Reset values (registers after posedge with i_rst = 1): r_b_wait = 0, r_rd_pend_a = r_rd_pend_b = 0. Hence o_a_rd_valid = o_b_rd_valid = 0.
- Reset mid-read: a read granted the cycle before reset is asserted has its valid suppressed. The requester must reissue the read.
- Grant latency: 0 cycles. Read data latency: 1 cycle after the grant cycle.
- Back-to-back grants are legal every cycle. Throughput is one access per cycle total.
- Port B worst-case wait with port A continuously requesting: it is denied for p_STARVE_LIMIT cycles and granted on cycle p_STARVE_LIMIT+1.
  - In that cycle port A is denied for one cycle.
  - r_b_wait then returns to 0.
- Simultaneous requests with r_b_wait < p_STARVE_LIMIT: A wins. With r_b_wait == p_STARVE_LIMIT: B wins.

## Test plan
- Reset:
  - Stimulus: assert i_rst for 2 cycles with i_a_req = i_b_req = 1.
  - Required: o_a_gnt = o_b_gnt = 0, o_mem_wr_en = 0, both rd_valid = 0; r_b_wait = 0 after release.
- Port A write/read:
  - Stimulus: A writes 0xBEEF to 0x010; next cycle A reads 0x010.
  - Required: gnt=1 both cycles; o_a_rd_valid = 1 one cycle after the read grant, with o_a_rd_data = 0xBEEF; o_b_rd_valid stays 0.
- Port B alone:
  - Stimulus: B reads address 0x3FF, pre-written with 0x1234.
  - Required: o_b_gnt = 1 the same cycle; o_b_rd_valid = 1 next cycle with data 0x1234.
- Starvation, p_STARVE_LIMIT = 4:
  - Stimulus: A reads every cycle while B requests continuously.
  - Required: B denied cycles 1–4 and granted on cycle 5 (o_a_gnt = 0 that cycle); A granted again on cycle 6; pattern repeats every 5 cycles.
- Interleaved return routing:
  - Stimulus: A read of 0x001 (0xAAAA), then B read of 0x002 (0x5555) in consecutive cycles.
  - Required: o_a_rd_valid with 0xAAAA, then o_b_rd_valid with 0x5555 the next cycle; never both high.
- Reset mid-read:
  - Stimulus: A read granted, i_rst asserted the following cycle.
  - Required: o_a_rd_valid = 0 after reset; no memory write occurs.
